mem_stage: RTL

//  LC-3 pipeline MEM stage; consumes the EX-stage result bundle (IR, NPC, ALU result, store data, branch cond/target).

---
 rtl/lc3_pkg.sv | 42 ++++
 rtl/mem_stage_if.sv | 12 +
 rtl/mem_watchdog.sv | 25 ++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, bubble encoding, MEM-stage access classes and FSM states.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RES  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    localparam logic [15:0] BUBBLE_IR_VAL      = 16'h9000;
    localparam int          TIMEOUT_CYCLES_DEF = 15;

    typedef enum logic [2:0] {
        MC_PASS, MC_READ, MC_WRITE, MC_IND_RD, MC_IND_WR
    } mem_class_e;

    typedef enum logic [1:0] {
        IDLE, ACCESS, INDIR
    } mem_state_e;

    function automatic mem_class_e mem_class(input logic [15:0] ir);
        case (ir[15:12])
            OP_LD, OP_LDR, OP_TRAP, OP_RTI: return MC_READ;
            OP_ST, OP_STR:                  return MC_WRITE;
            OP_LDI:                         return MC_IND_RD;
            OP_STI:                         return MC_IND_WR;
            default:                        return MC_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port between the MEM stage (master) and the memory (slave).
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_watchdog.sv
// Ack-wait counter for the MEM stage; expire_o flags the ack-less cycle that hits TIMEOUT_CYCLES.
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic tick_i,
    output logic expire_o
);
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)     count_d = 8'd0;
        else if (tick_i) count_d = count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= 8'd0;
        else        count_q <= count_d;
    end

    assign expire_o = tick_i && (count_q == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_stage.sv
// LC-3 MEM stage: data access over a req/ack port (two accesses for LDI/STI) and WB bundle register.
// Optional ack timeout with bus-error pulse when MEM_TIMEOUT_EN is defined.
module mem_stage
    import lc3_pkg::*;
#(
    parameter logic [15:0] BUBBLE_IR = BUBBLE_IR_VAL
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic [15:0] memIRin,
    input  logic [15:0] memNPCin,
    input  logic [15:0] memALUin,
    input  logic [15:0] memTMPin,
    input  logic        memCondin,
    input  logic [15:0] memPCin,
    mem_stage_if.master dmem,
    output logic        memStall,
    output logic [15:0] memIRout,
    output logic [15:0] memNPCout,
    output logic [15:0] memALUout,
    output logic [15:0] memLMD,
    output logic [15:0] memPCout,
    output logic        memCond,
    output logic        memBusErr
);
    mem_state_e  state_q, state_d;
    mem_class_e  cls_q, cls_d, in_cls;
    logic        req_q, req_d, we_q, we_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [15:0] ir_q, ir_d, npc_q, npc_d, alu_q, alu_d, lmd_q, lmd_d, pc_q, pc_d;
    logic        cond_q, cond_d;
    logic        mem_stall, latch, flush;
    logic [15:0] lmd_val;
    logic        expire;

    assign in_cls = mem_class(memIRin);
    assign flush  = irq && (state_q == IDLE);

`ifdef MEM_TIMEOUT_EN
    logic buserr_q, buserr_d;

    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  ((state_q == IDLE) || dmem.ack),
        .tick_i   ((state_q != IDLE) && !dmem.ack),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;  cls_d = cls_q;
        req_d = req_q;  we_d = we_q;  addr_d = addr_q;  wdata_d = wdata_q;
        ir_d = ir_q;  npc_d = npc_q;  alu_d = alu_q;  lmd_d = lmd_q;  pc_d = pc_q;  cond_d = cond_q;
        mem_stall = 1'b1;
        latch     = 1'b0;
        lmd_val   = 16'h0000;
        case (state_q)
            IDLE: begin
                if (irq || in_cls == MC_PASS) begin
                    mem_stall = 1'b0;
                    latch     = 1'b1;
                end else begin
                    state_d = ACCESS;
                    cls_d   = in_cls;
                    req_d   = 1'b1;
                    addr_d  = memALUin;
                    we_d    = (in_cls == MC_WRITE);
                    wdata_d = memTMPin;
                end
            end
            ACCESS: begin
                if (dmem.ack) begin
                    // Indirect ops reuse the read data as the pointer for the second access.
                    if (cls_q == MC_IND_RD || cls_q == MC_IND_WR) begin
                        state_d = INDIR;
                        addr_d  = dmem.rdata;
                        we_d    = (cls_q == MC_IND_WR);
                    end else begin
                        mem_stall = 1'b0;
                        latch     = 1'b1;
                        lmd_val   = (cls_q == MC_READ) ? dmem.rdata : 16'h0000;
                    end
                end
            end
            INDIR: begin
                if (dmem.ack) begin
                    mem_stall = 1'b0;
                    latch     = 1'b1;
                    lmd_val   = (cls_q == MC_IND_RD) ? dmem.rdata : 16'h0000;
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch) begin
            state_d = IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            ir_d    = flush ? BUBBLE_IR : memIRin;
            cond_d  = flush ? 1'b0 : memCondin;
            npc_d   = memNPCin;
            alu_d   = memALUin;
            pc_d    = memPCin;
            lmd_d   = lmd_val;
        end else begin
            ir_d   = BUBBLE_IR;
            cond_d = 1'b0;
        end

`ifdef MEM_TIMEOUT_EN
        buserr_d = 1'b0;
        if (expire) begin
            mem_stall = 1'b0;
            state_d   = IDLE;
            req_d     = 1'b0;
            we_d      = 1'b0;
            ir_d      = BUBBLE_IR;
            cond_d    = 1'b0;
            buserr_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;     cls_q   <= MC_PASS;
            req_q   <= 1'b0;     we_q    <= 1'b0;
            addr_q  <= 16'h0000; wdata_q <= 16'h0000;
            ir_q    <= BUBBLE_IR;
            npc_q   <= 16'h0000; alu_q   <= 16'h0000;
            lmd_q   <= 16'h0000; pc_q    <= 16'h0000;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;  cls_q   <= cls_d;
            req_q   <= req_d;    we_q    <= we_d;
            addr_q  <= addr_d;   wdata_q <= wdata_d;
            ir_q    <= ir_d;
            npc_q   <= npc_d;    alu_q   <= alu_d;
            lmd_q   <= lmd_d;    pc_q    <= pc_d;
            cond_q  <= cond_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) buserr_q <= 1'b0;
        else        buserr_q <= buserr_d;
    end
    assign memBusErr = buserr_q;
`else
    assign memBusErr = 1'b0;
`endif

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign memStall   = mem_stall;
    assign memIRout   = ir_q;
    assign memNPCout  = npc_q;
    assign memALUout  = alu_q;
    assign memLMD     = lmd_q;
    assign memPCout   = pc_q;
    assign memCond    = cond_q;
endmodule
